// File: rtl/axi_rd_burst_splitter.sv
// -----------------------------------------------------------------------------
// axi_rd_burst_splitter
//   Splits each upstream AXI INCR read burst into a sequence of single-beat
//   downstream reads (len=0) for slaves that cannot handle bursts. One burst
//   is in flight at a time; the beat address wraps inside its 4 KiB page.
//
// Ports
//   clk_i, rst_i              clock, asynchronous active-high reset
//   s_ar_*                    upstream AR channel (burst request)
//   s_r_*                     upstream R channel (one beat per downstream read)
//   m_ar_*                    downstream AR channel (single-beat requests)
//   m_r_*                     downstream R channel (m_r_last, m_r_id ignored)
//
// Build option
//   AXI_BURST_SPLIT_RREG_EN   when defined, the R path goes through a one-entry
//                             register and the FSM advances on the upstream
//                             handshake (one extra cycle per beat).
// -----------------------------------------------------------------------------
`timescale 1ns/1ps

module axi_rd_burst_splitter #(
    parameter int AddrWidth = 64,
    parameter int DataWidth = 64,
    parameter int IdWidth   = 4
) (
    input  logic                 clk_i,
    input  logic                 rst_i,
    // upstream AR
    input  logic                 s_ar_valid,
    output logic                 s_ar_ready,
    input  logic [AddrWidth-1:0] s_ar_addr,
    input  logic [7:0]           s_ar_len,
    input  logic [2:0]           s_ar_size,
    input  logic [IdWidth-1:0]   s_ar_id,
    // upstream R
    output logic                 s_r_valid,
    input  logic                 s_r_ready,
    output logic [DataWidth-1:0] s_r_data,
    output logic [1:0]           s_r_resp,
    output logic                 s_r_last,
    output logic [IdWidth-1:0]   s_r_id,
    // downstream AR
    output logic                 m_ar_valid,
    input  logic                 m_ar_ready,
    output logic [AddrWidth-1:0] m_ar_addr,
    output logic [7:0]           m_ar_len,
    output logic [2:0]           m_ar_size,
    output logic [IdWidth-1:0]   m_ar_id,
    // downstream R
    input  logic                 m_r_valid,
    output logic                 m_r_ready,
    input  logic [DataWidth-1:0] m_r_data,
    input  logic [1:0]           m_r_resp,
    input  logic                 m_r_last,
    input  logic [IdWidth-1:0]   m_r_id
);

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_REQ,
        ST_WAIT
    } state_t;

    state_t                 r_state;
    logic                   r_ar_ready;
    logic                   r_m_ar_valid;
    logic [AddrWidth-1:0]   r_addr;
    logic [7:0]             r_len;
    logic [7:0]             r_cnt;
    logic [2:0]             r_size;
    logic [IdWidth-1:0]     r_id;

    logic                   w_in_wait;
    logic                   w_last;
    logic                   w_r_hs;
    logic                   w_unused;

    assign w_in_wait = (r_state == ST_WAIT);
    assign w_last    = (r_cnt == r_len);
    assign w_r_hs    = s_r_valid & s_r_ready;

    // Downstream beat ID and last flag are regenerated locally.
    assign w_unused  = ^{m_r_last, m_r_id};

    assign s_ar_ready = r_ar_ready;
    assign m_ar_valid = r_m_ar_valid;
    assign m_ar_addr  = r_addr;
    assign m_ar_len   = '0;
    assign m_ar_size  = r_size;
    assign m_ar_id    = r_id;

`ifdef AXI_BURST_SPLIT_RREG_EN
    logic                   r_rv;
    logic [DataWidth-1:0]   r_rdata;
    logic [1:0]             r_rresp;
    logic                   r_rlast;
    logic [IdWidth-1:0]     r_rid;

    // Only one downstream read is outstanding per beat, so the register can
    // accept again in the same cycle it drains.
    assign m_r_ready = w_in_wait & (~r_rv | s_r_ready);
    assign s_r_valid = r_rv;
    assign s_r_data  = r_rdata;
    assign s_r_resp  = r_rresp;
    assign s_r_last  = r_rlast;
    assign s_r_id    = r_rid;

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            r_rv    <= 1'b0;
            r_rdata <= '0;
            r_rresp <= '0;
            r_rlast <= 1'b0;
            r_rid   <= '0;
        end else begin
            if (w_r_hs) begin
                r_rv <= 1'b0;
            end
            if (m_r_valid & m_r_ready) begin
                r_rv    <= 1'b1;
                r_rdata <= m_r_data;
                r_rresp <= m_r_resp;
                r_rlast <= w_last;
                r_rid   <= r_id;
            end
        end
    end
`else
    assign m_r_ready = w_in_wait & s_r_ready;
    assign s_r_valid = w_in_wait & m_r_valid;
    assign s_r_data  = m_r_data;
    assign s_r_resp  = m_r_resp;
    assign s_r_last  = w_in_wait & w_last;
    assign s_r_id    = r_id;
`endif

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            r_state      <= ST_IDLE;
            r_ar_ready   <= 1'b1;
            r_m_ar_valid <= 1'b0;
            r_addr       <= '0;
            r_len        <= '0;
            r_cnt        <= '0;
            r_size       <= '0;
            r_id         <= '0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (s_ar_valid) begin
                        r_addr       <= s_ar_addr;
                        r_len        <= s_ar_len;
                        r_size       <= s_ar_size;
                        r_id         <= s_ar_id;
                        r_cnt        <= '0;
                        r_ar_ready   <= 1'b0;
                        r_m_ar_valid <= 1'b1;
                        r_state      <= ST_REQ;
                    end
                end
                ST_REQ: begin
                    if (m_ar_ready) begin
                        r_m_ar_valid <= 1'b0;
                        r_state      <= ST_WAIT;
                    end
                end
                ST_WAIT: begin
                    if (w_r_hs) begin
                        if (w_last) begin
                            r_ar_ready <= 1'b1;
                            r_state    <= ST_IDLE;
                        end else begin
                            // Increment stays inside the 4 KiB page.
                            r_addr[11:0] <= r_addr[11:0] + (12'd1 << r_size);
                            r_cnt        <= r_cnt + 8'd1;
                            r_m_ar_valid <= 1'b1;
                            r_state      <= ST_REQ;
                        end
                    end
                end
                default: begin
                    r_ar_ready   <= 1'b1;
                    r_m_ar_valid <= 1'b0;
                    r_state      <= ST_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_axi_rd_burst_splitter.sv
// -----------------------------------------------------------------------------
// tb_axi_rd_burst_splitter
//   Directed bench for axi_rd_burst_splitter (default build). A behavioural
//   single-beat slave answers each downstream AR one cycle later with data
//   derived from the address; upstream and downstream traffic is logged on the
//   falling edge and compared against hand-computed values.
// -----------------------------------------------------------------------------
`timescale 1ns/1ps

module tb_axi_rd_burst_splitter;

    localparam int AW = 64;
    localparam int DW = 64;
    localparam int IW = 4;

    logic          clk = 1'b0;
    logic          rst_i;
    logic          s_ar_valid;
    logic          s_ar_ready;
    logic [AW-1:0] s_ar_addr;
    logic [7:0]    s_ar_len;
    logic [2:0]    s_ar_size;
    logic [IW-1:0] s_ar_id;
    logic          s_r_valid;
    logic          s_r_ready;
    logic [DW-1:0] s_r_data;
    logic [1:0]    s_r_resp;
    logic          s_r_last;
    logic [IW-1:0] s_r_id;
    logic          m_ar_valid;
    logic          m_ar_ready;
    logic [AW-1:0] m_ar_addr;
    logic [7:0]    m_ar_len;
    logic [2:0]    m_ar_size;
    logic [IW-1:0] m_ar_id;
    logic          m_r_valid = 1'b0;
    logic          m_r_ready;
    logic [DW-1:0] m_r_data  = '0;
    logic [1:0]    m_r_resp  = '0;
    logic          m_r_last  = 1'b1;
    logic [IW-1:0] m_r_id    = 4'hF;

    always #5 clk = ~clk;

    axi_rd_burst_splitter #(
        .AddrWidth (AW),
        .DataWidth (DW),
        .IdWidth   (IW)
    ) dut (
        .clk_i      (clk),
        .rst_i      (rst_i),
        .s_ar_valid (s_ar_valid),
        .s_ar_ready (s_ar_ready),
        .s_ar_addr  (s_ar_addr),
        .s_ar_len   (s_ar_len),
        .s_ar_size  (s_ar_size),
        .s_ar_id    (s_ar_id),
        .s_r_valid  (s_r_valid),
        .s_r_ready  (s_r_ready),
        .s_r_data   (s_r_data),
        .s_r_resp   (s_r_resp),
        .s_r_last   (s_r_last),
        .s_r_id     (s_r_id),
        .m_ar_valid (m_ar_valid),
        .m_ar_ready (m_ar_ready),
        .m_ar_addr  (m_ar_addr),
        .m_ar_len   (m_ar_len),
        .m_ar_size  (m_ar_size),
        .m_ar_id    (m_ar_id),
        .m_r_valid  (m_r_valid),
        .m_r_ready  (m_r_ready),
        .m_r_data   (m_r_data),
        .m_r_resp   (m_r_resp),
        .m_r_last   (m_r_last),
        .m_r_id     (m_r_id)
    );

    int n_vec     = 0;
    int n_miscmp  = 0;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_miscmp++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // Slave data pattern: easy to recompute for any address.
    function automatic logic [63:0] fdata(input logic [63:0] a);
        return a ^ 64'hA5A5_5A5A_0000_0000;
    endfunction

    // Traffic logs (written only by the slave/monitor process)
    logic [63:0] ar_addr_log [64];
    logic [7:0]  ar_len_log  [64];
    logic [2:0]  ar_size_log [64];
    logic [3:0]  ar_id_log   [64];
    logic [63:0] r_data_log  [64];
    logic [1:0]  r_resp_log  [64];
    logic        r_last_log  [64];
    logic [3:0]  r_id_log    [64];
    int          n_ar = 0;
    int          n_r  = 0;

    // Response code per downstream AR index (written by the main process)
    logic [1:0]  resp_by_ar  [64];

    logic        sl_ar_hs;
    logic        sl_r_hs;
    logic        sl_rst;
    logic [63:0] sl_addr;
    logic [1:0]  sl_resp;

    always begin
        @(negedge clk);
        sl_rst   = rst_i;
        sl_ar_hs = m_ar_valid && m_ar_ready && !rst_i;
        sl_r_hs  = m_r_valid && m_r_ready;
        sl_addr  = m_ar_addr;
        sl_resp  = 2'b00;
        if (sl_ar_hs && n_ar < 64) begin
            ar_addr_log[n_ar] = m_ar_addr;
            ar_len_log[n_ar]  = m_ar_len;
            ar_size_log[n_ar] = m_ar_size;
            ar_id_log[n_ar]   = m_ar_id;
            sl_resp           = resp_by_ar[n_ar];
            n_ar++;
        end
        if (s_r_valid && s_r_ready && !rst_i && n_r < 64) begin
            r_data_log[n_r] = s_r_data;
            r_resp_log[n_r] = s_r_resp;
            r_last_log[n_r] = s_r_last;
            r_id_log[n_r]   = s_r_id;
            n_r++;
        end
        @(posedge clk);
        #1;
        if (sl_rst || sl_r_hs) m_r_valid = 1'b0;
        if (sl_ar_hs) begin
            m_r_valid = 1'b1;
            m_r_data  = fdata(sl_addr);
            m_r_resp  = sl_resp;
        end
    end

    // Present one AR and hold it until accepted; entered and left at posedge+1.
    task automatic issue(input logic [63:0] a, input logic [7:0] l,
                         input logic [2:0] sz, input logic [3:0] id);
        logic ok;
        s_ar_valid = 1'b1;
        s_ar_addr  = a;
        s_ar_len   = l;
        s_ar_size  = sz;
        s_ar_id    = id;
        ok = 1'b0;
        for (int i = 0; i < 50 && !ok; i++) begin
            @(negedge clk);
            ok = s_ar_ready;
            @(posedge clk);
            #1;
        end
        s_ar_valid = 1'b0;
        if (!ok) check("ar_accept_timeout", 64'(ok), 64'd1);
    endtask

    // Counts falling edges with s_ar_ready low until the block is idle again.
    task automatic wait_idle(output int cyc);
        logic done;
        done = 1'b0;
        cyc  = 0;
        for (int i = 0; i < 200 && !done; i++) begin
            @(negedge clk);
            if (s_ar_ready) done = 1'b1;
            else cyc++;
        end
        if (!done) check("idle_timeout", 64'(done), 64'd1);
        @(posedge clk);
        #1;
    endtask

    int  b_ar;
    int  b_r;
    int  cyc;
    int  ar_seen;
    logic ok;

    initial begin
        for (int i = 0; i < 64; i++) resp_by_ar[i] = 2'b00;
        rst_i      = 1'b1;
        s_ar_valid = 1'b0;
        s_ar_addr  = '0;
        s_ar_len   = '0;
        s_ar_size  = '0;
        s_ar_id    = '0;
        s_r_ready  = 1'b1;
        m_ar_ready = 1'b1;

        // Reset state
        repeat (2) @(posedge clk);
        @(negedge clk);
        check("rst_s_ar_ready", 64'(s_ar_ready), 64'd1);
        check("rst_m_ar_valid", 64'(m_ar_valid), 64'd0);
        check("rst_s_r_valid",  64'(s_r_valid),  64'd0);
        check("rst_m_r_ready",  64'(m_r_ready),  64'd0);
        @(posedge clk);
        #1;
        rst_i = 1'b0;
        @(posedge clk);
        #1;

        // Two-beat burst, 8-byte beats
        b_ar = n_ar; b_r = n_r;
        issue(64'h1000, 8'd1, 3'd3, 4'd2);
        wait_idle(cyc);
        check("t1_cycles",   64'(cyc), 64'd4);
        check("t1_n_ar",     64'(n_ar - b_ar), 64'd2);
        check("t1_ar0_addr", ar_addr_log[b_ar],   64'h1000);
        check("t1_ar1_addr", ar_addr_log[b_ar+1], 64'h1008);
        check("t1_ar0_len",  64'(ar_len_log[b_ar]),   64'd0);
        check("t1_ar1_len",  64'(ar_len_log[b_ar+1]), 64'd0);
        check("t1_ar_size",  64'(ar_size_log[b_ar]),  64'd3);
        check("t1_ar_id",    64'(ar_id_log[b_ar+1]),  64'd2);
        check("t1_n_r",      64'(n_r - b_r), 64'd2);
        check("t1_r0_last",  64'(r_last_log[b_r]),   64'd0);
        check("t1_r1_last",  64'(r_last_log[b_r+1]), 64'd1);
        check("t1_r0_id",    64'(r_id_log[b_r]),     64'd2);
        check("t1_r1_id",    64'(r_id_log[b_r+1]),   64'd2);
        check("t1_r0_data",  r_data_log[b_r],   fdata(64'h1000));
        check("t1_r1_data",  r_data_log[b_r+1], fdata(64'h1008));

        // 4 KiB wrap keeps upper address bits
        b_ar = n_ar; b_r = n_r;
        issue(64'h0000_00AB_0000_1FF8, 8'd1, 3'd3, 4'd5);
        wait_idle(cyc);
        check("t2_n_ar",     64'(n_ar - b_ar), 64'd2);
        check("t2_ar0_addr", ar_addr_log[b_ar],   64'h0000_00AB_0000_1FF8);
        check("t2_ar1_addr", ar_addr_log[b_ar+1], 64'h0000_00AB_0000_1000);
        check("t2_r1_data",  r_data_log[b_r+1], fdata(64'h0000_00AB_0000_1000));

        // Single-beat burst
        b_ar = n_ar; b_r = n_r;
        issue(64'h2040, 8'd0, 3'd2, 4'd7);
        wait_idle(cyc);
        check("t3_cycles",  64'(cyc), 64'd2);
        check("t3_n_ar",    64'(n_ar - b_ar), 64'd1);
        check("t3_ar_addr", ar_addr_log[b_ar], 64'h2040);
        check("t3_ar_size", 64'(ar_size_log[b_ar]), 64'd2);
        check("t3_n_r",     64'(n_r - b_r), 64'd1);
        check("t3_r_last",  64'(r_last_log[b_r]), 64'd1);
        check("t3_r_id",    64'(r_id_log[b_r]),   64'd7);

        // SLVERR on first beat, burst still completes
        b_ar = n_ar; b_r = n_r;
        resp_by_ar[n_ar] = 2'b10;
        issue(64'h3000, 8'd1, 3'd3, 4'd1);
        wait_idle(cyc);
        check("t4_n_ar",    64'(n_ar - b_ar), 64'd2);
        check("t4_r0_resp", 64'(r_resp_log[b_r]),   64'd2);
        check("t4_r1_resp", 64'(r_resp_log[b_r+1]), 64'd0);
        check("t4_r1_last", 64'(r_last_log[b_r+1]), 64'd1);

        // Upstream back-pressure for three cycles
        b_ar = n_ar; b_r = n_r;
        s_r_ready = 1'b0;
        issue(64'h4000, 8'd1, 3'd3, 4'd3);
        ok = 1'b0;
        for (int i = 0; i < 20 && !ok; i++) begin
            @(negedge clk);
            ok = s_r_valid;
            if (!ok) begin
                @(posedge clk);
                #1;
            end
        end
        check("t5_rvalid_seen", 64'(ok), 64'd1);
        for (int k = 0; k < 3; k++) begin
            if (k > 0) @(negedge clk);
            check("t5_m_r_ready", 64'(m_r_ready),  64'd0);
            check("t5_data_held", s_r_data, fdata(64'h4000));
            check("t5_no_ar",     64'(m_ar_valid), 64'd0);
        end
        @(posedge clk);
        #1;
        check("t5_n_ar_stall", 64'(n_ar - b_ar), 64'd1);
        s_r_ready = 1'b1;
        wait_idle(cyc);
        check("t5_n_ar",     64'(n_ar - b_ar), 64'd2);
        check("t5_ar1_addr", ar_addr_log[b_ar+1], 64'h4008);
        check("t5_r0_data",  r_data_log[b_r],   fdata(64'h4000));
        check("t5_r1_data",  r_data_log[b_r+1], fdata(64'h4008));

        // Reset while waiting on the first beat of a four-beat burst
        b_ar = n_ar; b_r = n_r;
        s_r_ready = 1'b0;
        issue(64'h5000, 8'd3, 3'd3, 4'd4);
        ok = 1'b0;
        for (int i = 0; i < 20 && !ok; i++) begin
            @(negedge clk);
            ok = s_r_valid;
            if (!ok) begin
                @(posedge clk);
                #1;
            end
        end
        check("t6_rvalid_seen", 64'(ok), 64'd1);
        @(posedge clk);
        #1;
        rst_i = 1'b1;
        @(negedge clk);
        check("t6_s_ar_ready", 64'(s_ar_ready), 64'd1);
        check("t6_m_ar_valid", 64'(m_ar_valid), 64'd0);
        check("t6_s_r_valid",  64'(s_r_valid),  64'd0);
        check("t6_m_r_ready",  64'(m_r_ready),  64'd0);
        @(posedge clk);
        #1;
        rst_i     = 1'b0;
        s_r_ready = 1'b1;
        ar_seen   = 0;
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            if (m_ar_valid) ar_seen++;
        end
        check("t6_ar_after_rst", 64'(ar_seen), 64'd0);
        check("t6_n_ar",         64'(n_ar - b_ar), 64'd1);
        check("t6_n_r",          64'(n_r - b_r),   64'd0);
        check("t6_idle_ready",   64'(s_ar_ready),  64'd1);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miscmp);
        $finish;
    end

endmodule
